// File: rtl/toy_bus_pkg.sv
// Shared bus widths, opcodes and the request payload bundle for the toy bus slices.
package toy_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              opcode;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } req_pld_t;

  localparam int unsigned REQ_PLD_W = ADDR_W + DATA_W + STRB_W + 1 + 2 * ID_W;

endpackage

// File: rtl/toy_bus_skid_buf.sv
// Two-entry skid buffer: main register drives the output, skid catches one beat of
// backpressure so the upstream ready comes straight from a flop.
module toy_bus_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         fire_in, fire_out;

  assign in_rdy   = !skid_vld_q;
  assign out_vld  = main_vld_q;
  assign out_data = main_q;
  assign fire_in  = in_vld & !skid_vld_q;
  assign fire_out = main_vld_q & out_rdy;

  // Main refills whenever it is empty or draining; skid only fills behind a stalled main.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || fire_out) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = fire_in;
        if (fire_in) begin
          main_d = in_data;
        end
      end
    end else if (fire_in) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Payload is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/toy_bus_fetch_req_slice.sv
// Fetch-port request slice: registered request path with outstanding-request limit,
// combinational ack pass-through with sticky misroute/unexpected-ack detection.
module toy_bus_fetch_req_slice
  import toy_bus_pkg::*;
#(
  parameter int unsigned MAX_OSTD = 4,
  parameter int unsigned SRC_ID   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req_vld,
  output logic              in_req_rdy,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [DATA_W-1:0] in_req_data,
  input  logic [STRB_W-1:0] in_req_strb,
  input  logic              in_req_opcode,
  input  logic [ID_W-1:0]   in_req_src_id,
  input  logic [ID_W-1:0]   in_req_tgt_id,
  output logic              out_req_vld,
  input  logic              out_req_rdy,
  output logic [ADDR_W-1:0] out_req_addr,
  output logic [DATA_W-1:0] out_req_data,
  output logic [STRB_W-1:0] out_req_strb,
  output logic              out_req_opcode,
  output logic [ID_W-1:0]   out_req_src_id,
  output logic [ID_W-1:0]   out_req_tgt_id,
  input  logic              out_ack_vld,
  output logic              out_ack_rdy,
  input  logic              out_ack_opcode,
  input  logic [DATA_W-1:0] out_ack_data,
  input  logic [ID_W-1:0]   out_ack_src_id,
  input  logic [ID_W-1:0]   out_ack_tgt_id,
  output logic              in_ack_vld,
  input  logic              in_ack_rdy,
  output logic              in_ack_opcode,
  output logic [DATA_W-1:0] in_ack_data,
  output logic [ID_W-1:0]   in_ack_src_id,
  output logic [ID_W-1:0]   in_ack_tgt_id,
  output logic [CNT_W-1:0]  ostd_cnt,
  output logic              err_ack
);

  req_pld_t           in_pld;
  req_pld_t           out_pld;
  logic               main_vld;
  logic               issue_ok;
  logic               buf_out_rdy;
  logic               fire_out;
  logic               ack_hs;
  logic               ack_bad;
  logic [CNT_W-1:0]   ostd_cnt_q, ostd_cnt_d;
  logic               err_ack_q, err_ack_d;

  assign in_pld = '{addr:   in_req_addr,
                    data:   in_req_data,
                    strb:   in_req_strb,
                    opcode: in_req_opcode,
                    src_id: in_req_src_id,
                    tgt_id: in_req_tgt_id};

  assign issue_ok    = ostd_cnt_q < CNT_W'(MAX_OSTD);
  assign buf_out_rdy = out_req_rdy & issue_ok;

  toy_bus_skid_buf #(
    .W (REQ_PLD_W)
  ) u_req_buf (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_req_vld),
    .in_rdy   (in_req_rdy),
    .in_data  (in_pld),
    .out_vld  (main_vld),
    .out_rdy  (buf_out_rdy),
    .out_data (out_pld)
  );

  assign out_req_vld    = main_vld & issue_ok;
  assign fire_out       = out_req_vld & out_req_rdy;
  assign out_req_addr   = out_pld.addr;
  assign out_req_data   = out_pld.data;
  assign out_req_strb   = out_pld.strb;
  assign out_req_opcode = out_pld.opcode;
  assign out_req_src_id = out_pld.src_id;
  assign out_req_tgt_id = out_pld.tgt_id;

  assign in_ack_vld    = out_ack_vld;
  assign out_ack_rdy   = in_ack_rdy;
  assign in_ack_opcode = out_ack_opcode;
  assign in_ack_data   = out_ack_data;
  assign in_ack_src_id = out_ack_src_id;
  assign in_ack_tgt_id = out_ack_tgt_id;

  assign ack_hs  = out_ack_vld & in_ack_rdy;
  assign ack_bad = (out_ack_tgt_id != ID_W'(SRC_ID)) || ((ostd_cnt_q == '0) && !fire_out);

  // Outstanding count saturates at zero on an unexpected ack; the error flag records it.
  always_comb begin
    ostd_cnt_d = ostd_cnt_q;
    err_ack_d  = err_ack_q;
    if (fire_out && !ack_hs) begin
      ostd_cnt_d = ostd_cnt_q + CNT_W'(1);
    end else if (ack_hs && !fire_out && (ostd_cnt_q != '0)) begin
      ostd_cnt_d = ostd_cnt_q - CNT_W'(1);
    end
    if (ack_hs && ack_bad) begin
      err_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ostd_cnt_q <= '0;
      err_ack_q  <= 1'b0;
    end else begin
      ostd_cnt_q <= ostd_cnt_d;
      err_ack_q  <= err_ack_d;
    end
  end

  assign ostd_cnt = ostd_cnt_q;
  assign err_ack  = err_ack_q;

endmodule

// File: doc/toy_bus_fetch_req_slice.md
Name: toy_bus_fetch_req_slice

Overview:
- Sits directly downstream of the fetch-port bus node, between the node's routed request/ack interface (src_id/tgt_id attached) and the bus network.
- Registers the request path through a 2-entry skid buffer, giving full throughput with no combinational ready path.
- Counts outstanding requests and stops issuing at MAX_OSTD.
- Passes acks back upstream combinationally and flags acks that are misrouted or unexpected.

Parameters:
- MAX_OSTD, 4, maximum requests accepted downstream without an ack yet (1..15).
- SRC_ID, 0, this port's bus id; every ack must carry tgt_id == SRC_ID.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_req_vld  in  1  request valid from node
- in_req_rdy  out  1  request ready to node
- in_req_addr  in  32  request address
- in_req_data  in  32  write data
- in_req_strb  in  4  byte strobes
- in_req_opcode  in  1  0=read, 1=write
- in_req_src_id  in  4  source id
- in_req_tgt_id  in  4  target id
- out_req_vld / out_req_rdy  out / in  1 / 1  request handshake to network
- out_req_addr, out_req_data, out_req_strb, out_req_opcode, out_req_src_id, out_req_tgt_id  out  32,32,4,1,4,4  registered request payload
- out_ack_vld / out_ack_rdy  in / out  1 / 1  ack handshake from network
- out_ack_opcode, out_ack_data, out_ack_src_id, out_ack_tgt_id  in  1,32,4,4  ack payload
- in_ack_vld / in_ack_rdy  out / in  1 / 1  ack handshake to node
- in_ack_opcode, in_ack_data, in_ack_src_id, in_ack_tgt_id  out  1,32,4,4  ack payload to node
- ostd_cnt  out  4  current outstanding count
- err_ack  out  1  sticky error flag

Behaviour:
- Reset values: main_vld=0, skid_vld=0, ostd_cnt=0, err_ack=0, in_req_rdy=1.
- Payload registers are not reset; out_req_* payload is X until the first load.
- Request storage is a main register (drives out_req_*) plus a skid register.
- in_req_rdy = !skid_vld, taken from a flop, never combinational from out_req_rdy.
- Issue gate: issue_ok = (ostd_cnt < MAX_OSTD).
- out_req_vld = main_vld & issue_ok.
- fire_out = out_req_vld & out_req_rdy.
- fire_in = in_req_vld & in_req_rdy.
- Storage update rules:
  - Main empty, or fire_out: main loads from skid if skid_vld (skid clears), else from input if fire_in.
  - Main held (valid, not firing) and fire_in: skid loads from input.
- Latency in->out is 1 cycle. Sustained throughput is 1/cycle while out_req_rdy=1 and issue_ok.
- A req is never dropped, duplicated or reordered.
- While out_req_rdy=0 or issue_ok=0, at most 2 requests are held; the third is backpressured.
- Outstanding counter:
  - Increments on fire_out, decrements on ack handshake (out_ack_vld & out_ack_rdy).
  - Both in the same cycle: unchanged.
  - At MAX_OSTD, out_req_vld drops the next cycle; the counter never exceeds MAX_OSTD.
- Ack path is combinational pass-through:
  - in_ack_vld = out_ack_vld; out_ack_rdy = in_ack_rdy; payload passes straight through.
- err_ack sets on any ack handshake where out_ack_tgt_id != SRC_ID, or ostd_cnt == 0 with no same-cycle fire_out.
- On the underflow case the counter stays 0.
- err_ack clears only on rst.
- Reset mid-operation: all held requests are discarded and the count returns to 0. Acks arriving after reset for pre-reset requests raise err_ack.

Decomposition:
- Shared package toy_bus_pkg holds:
  - ADDR_W=32, DATA_W=32, STRB_W=4, ID_W=4
  - OPC_RD=0, OPC_WR=1
  - the request payload bundle width constant (REQ_PLD_W = 77)
- One natural sub-module: toy_bus_skid_buf (parameterised width, 2 entries, vld/rdy both sides), instantiated once on the request payload.
- The counter and error logic live in the top.

Test Plan:
- Stream of 4 reqs, addr 0x8000_0000 + 4n, out_req_rdy=1, acks returned 2 cycles later -> out_req_* match each input 1 cycle later, in_req_rdy stays 1, ostd_cnt peaks at 2 and ends at 0.
- out_req_rdy=0 for 5 cycles while 3 reqs are offered -> in_req_rdy falls after 2 accepted; after release, order is addr A, B, C with no gaps.
- MAX_OSTD=2, no acks, 4 reqs -> exactly 2 issued, out_req_vld=0 with main and skid full, ostd_cnt=2. One ack -> 3rd issues the next cycle.
- Ack handshake and fire_out in the same cycle at ostd_cnt=1 -> ostd_cnt stays 1, err_ack=0.
- Ack with tgt_id=4'h3 (SRC_ID=0) -> passes to in_ack_*, err_ack=1 from the next cycle and stays high.
- Ack at ostd_cnt=0 -> err_ack=1, counter stays 0.
- rst pulsed with 2 reqs held and ostd_cnt=3 -> next cycle out_req_vld=0, in_req_rdy=1, ostd_cnt=0, err_ack=0.
